// File: rtl/f1_io_controller.sv
`default_nettype none
// f1_io_controller: button conditioning, seed generation, lamp drive and
// reaction-time measurement for the F1 start-lights program.
module f1_io_controller #(
  parameter int DATAWIDTH       = 32,
  parameter int LIGHTS          = 8,
  parameter int LFSR_WIDTH      = 7,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_i,
  input  logic [DATAWIDTH-1:0] a0,
  output logic                 t0,
  output logic [DATAWIDTH-1:0] t4,
  output logic [LIGHTS-1:0]    lights,
  output logic [DATAWIDTH-1:0] reaction_count,
  output logic                 reaction_valid,
  output logic                 jump_start
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, SEQUENCE, FULL, TIMING} state_t;

  state_t                 state, state_nxt;
  logic                   sync_m, sync, btn_db, btn_db_q, press;
  logic [CW-1:0]          db_cnt;
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic [DATAWIDTH-1:0]   timer;
  logic                   capture, jump_nxt, valid_nxt, timer_clr;
  logic                   unused_a0_hi;

  assign unused_a0_hi = ^a0[DATAWIDTH-1:LIGHTS];
  assign press        = btn_db & ~btn_db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_m   <= 1'b0;
      sync     <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
      lfsr     <= LFSR_WIDTH'(1);
      lights   <= '0;
    end else begin
      sync_m   <= btn_i;
      sync     <= sync_m;
      btn_db_q <= btn_db;
      if (sync != btn_db) begin
        if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      // x^7+x^6+1: feedback from the two top taps, never reaches zero
      lfsr   <= {lfsr[LFSR_WIDTH-2:0], lfsr[LFSR_WIDTH-1] ^ lfsr[LFSR_WIDTH-2]};
      lights <= a0[LIGHTS-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    jump_nxt  = 1'b0;
    valid_nxt = 1'b0;
    timer_clr = 1'b0;
    case (state)
      IDLE: if (press) begin
        state_nxt = ARMED;
        capture   = 1'b1;
      end
      ARMED: if (lights != '0) state_nxt = SEQUENCE;
      // a press always takes priority over a lamp transition
      SEQUENCE: begin
        if (press) begin
          jump_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (lights == '1) begin
          state_nxt = FULL;
        end else if (lights == '0) begin
          state_nxt = IDLE;
        end
      end
      FULL: begin
        if (press) begin
          jump_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (lights == '0) begin
          state_nxt = TIMING;
          timer_clr = 1'b1;
        end
      end
      TIMING: if (press) begin
        valid_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      t0             <= 1'b0;
      t4             <= '0;
      timer          <= '0;
      reaction_count <= '0;
      reaction_valid <= 1'b0;
      jump_start     <= 1'b0;
    end else begin
      state          <= state_nxt;
      t0             <= (state_nxt == ARMED);
      reaction_valid <= valid_nxt;
      jump_start     <= jump_nxt;
      if (capture) t4 <= {{(DATAWIDTH-LFSR_WIDTH){1'b0}}, lfsr};
      if (jump_nxt) reaction_count <= '0;
      else if (valid_nxt) reaction_count <= timer;
      if (timer_clr) timer <= '0;
      else if (state == TIMING && timer != '1) timer <= timer + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f1_io_controller.sv
`default_nettype none
// tb_f1_io_controller: directed vectors with hand-computed expectations.
module tb_f1_io_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_i = 1'b0;
  logic [31:0] a0 = '0;
  logic        t0;
  logic [31:0] t4;
  logic [7:0]  lights;
  logic [31:0] reaction_count;
  logic        reaction_valid;
  logic        jump_start;

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;
  int rv_cnt = 0;
  int js_cnt = 0;

  f1_io_controller #(
    .DATAWIDTH(32), .LIGHTS(8), .LFSR_WIDTH(7), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_i), .a0(a0), .t0(t0), .t4(t4),
    .lights(lights), .reaction_count(reaction_count),
    .reaction_valid(reaction_valid), .jump_start(jump_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reaction_valid) rv_cnt++;
    if (jump_start) js_cnt++;
    if (reaction_valid | jump_start) chk("pulse_excl", {31'd0, reaction_valid & jump_start}, 32'd0);
  end

  function automatic logic [6:0] lfsr_at(input int n);
    logic [6:0] v;
    v = 7'h01;
    for (int i = 0; i < n; i++) v = {v[5:0], v[6] ^ v[5]};
    return v;
  endfunction

  task automatic step(input logic [7:0] v);
    a0 = {24'd0, v};
    @(negedge clk);
    chk("lights", {24'd0, lights}, {24'd0, v});
  endtask

  task automatic ramp_full();
    step(8'h01); step(8'h03);
    chk("t0_drop", {31'd0, t0}, 32'd0);
    step(8'h07); step(8'h0F); step(8'h1F); step(8'h3F); step(8'h7F); step(8'hFF);
  endtask

  task automatic do_press(input string tag);
    int i;
    i = 0;
    btn_i = 1'b1;
    while (t0 !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_t0"}, {31'd0, t0}, 32'd1);
    chk({tag, "_t4"}, t4, {25'd0, lfsr_at(ecnt - 1)});
    btn_i = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  logic [7:0]  lfsr_exp [7];
  logic [31:0] t4_prev;
  int          rv0, js0, k;

  initial begin
    lfsr_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_t0", {31'd0, t0}, 32'd0);
    chk("rst_t4", t4, 32'd0);
    chk("rst_lights", {24'd0, lights}, 32'd0);
    chk("rst_rc", reaction_count, 32'd0);
    chk("rst_rv", {31'd0, reaction_valid}, 32'd0);
    chk("rst_js", {31'd0, jump_start}, 32'd0);
    rst_n = 1'b1;
    chk("lfsr0", {25'd0, dut.lfsr}, 32'h01);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("lfsr_step", {25'd0, dut.lfsr}, {24'd0, lfsr_exp[i]});
    end

    // 3-cycle glitch is rejected
    btn_i = 1'b1;
    repeat (3) @(negedge clk);
    btn_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("glitch_t0", {31'd0, t0}, 32'd0);
    end

    // t0 rises on the 7th edge counting the first sampling edge as 1
    btn_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lat_lo", {31'd0, t0}, 32'd0);
    end
    @(negedge clk);
    chk("lat_hi", {31'd0, t0}, 32'd1);
    chk("lat_t4", t4, {25'd0, lfsr_at(ecnt - 1)});
    btn_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("armed_hold", {31'd0, t0}, 32'd1);

    // abort from SEQUENCE with lights at 0x07
    t4_prev = t4;
    rv0 = rv_cnt; js0 = js_cnt;
    step(8'h01); step(8'h03); step(8'h07); step(8'h00); step(8'h00);
    chk("abort_t0", {31'd0, t0}, 32'd0);
    chk("abort_rv", rv_cnt - rv0, 32'd0);
    chk("abort_js", js_cnt - js0, 32'd0);
    do_press("restart");
    chk("t4_new", {31'd0, t4 != t4_prev}, 32'd1);
    step(8'h01); step(8'h00); step(8'h00);

    // full run, press so that 50 TIMING cycles elapse first
    do_press("run");
    rv0 = rv_cnt; js0 = js_cnt;
    ramp_full();
    step(8'h00);
    repeat (45) @(negedge clk);
    btn_i = 1'b1;
    k = 0;
    while (reaction_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("run_rv", {31'd0, reaction_valid}, 32'd1);
    chk("run_rc", reaction_count, 32'd50);
    @(negedge clk);
    chk("run_rv_pulse", {31'd0, reaction_valid}, 32'd0);
    btn_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("run_rv_cnt", rv_cnt - rv0, 32'd1);
    chk("run_js_cnt", js_cnt - js0, 32'd0);
    chk("run_rc_hold", reaction_count, 32'd50);
    chk("run_idle_t0", {31'd0, t0}, 32'd0);

    // jump start while all lamps lit
    do_press("js");
    rv0 = rv_cnt; js0 = js_cnt;
    ramp_full();
    step(8'hFF);
    btn_i = 1'b1;
    k = 0;
    while (jump_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("js_pulse", {31'd0, jump_start}, 32'd1);
    chk("js_rc", reaction_count, 32'd0);
    chk("js_rv", {31'd0, reaction_valid}, 32'd0);
    chk("js_t0", {31'd0, t0}, 32'd0);
    @(negedge clk);
    chk("js_pulse_end", {31'd0, jump_start}, 32'd0);
    btn_i = 1'b0;
    step(8'h00);
    repeat (10) @(negedge clk);
    chk("js_cnt", js_cnt - js0, 32'd1);
    chk("js_rv_cnt", rv_cnt - rv0, 32'd0);

    // asynchronous reset in the middle of TIMING
    do_press("rt");
    ramp_full();
    step(8'h00);
    step(8'hA5);
    rv0 = rv_cnt; js0 = js_cnt;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_t4", t4, 32'd0);
    chk("arst_lights", {24'd0, lights}, 32'd0);
    chk("arst_t0", {31'd0, t0}, 32'd0);
    chk("arst_rc", reaction_count, 32'd0);
    a0 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_press("fresh");
    chk("arst_rv_cnt", rv_cnt - rv0, 32'd0);
    chk("arst_js_cnt", js_cnt - js0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
